// File: rtl/osd_string_writer.sv
// OSD string writer: streams a NUL-terminated string from the string ROM into
// character RAM at one character per cycle, with optional field padding and highlight.
`timescale 1ns/1ps
module osd_string_writer #(
    parameter int          ADDR_W   = 11,
    parameter int          IDX_W    = 6,
    parameter int          STR_AW   = 9,
    parameter int          FIELD_W  = 0,
    parameter int          MAX_LEN  = 32,
    parameter logic [7:0]  PAD_CHAR = 8'h20,
    parameter string       STR_INIT = "",
    parameter string       OFS_INIT = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [ADDR_W-1:0] req_base,
    input  logic              req_hilite,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              done,
    output logic [7:0]        str_len
);

    localparam int NUM_STR   = 2**IDX_W;
    localparam int STR_DEPTH = 2**STR_AW;
    localparam int LIMIT     = (FIELD_W > 0) ? FIELD_W : MAX_LEN;
    localparam int CNT_W     = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam bit   PAD_EN  = (FIELD_W > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_OFS, S_PRIME, S_STREAM, S_PAD, S_DONE
    } state_t;

    state_t             state;
    logic [7:0]         str_rom [STR_DEPTH];
    logic [STR_AW-1:0]  ofs_rom [NUM_STR];

    logic [IDX_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  base_q;
    logic               hilite_q;
    logic [STR_AW-1:0]  ofs_q;
    logic [7:0]         rom_q;
    logic [STR_AW-1:0]  fetch_i;
    logic [CNT_W-1:0]   out_i;

    logic               load;
    logic               at_limit;
    logic               is_nul;
    logic               advance;
    logic               rom_en;
    logic [STR_AW-1:0]  rom_addr;
    logic [7:0]         hi_mask;
    logic [ADDR_W-1:0]  out_addr;

    // The output register may take a new character when it is empty or being accepted.
    assign load     = !wr_en || wr_ready;
    assign at_limit = (out_i == LIMIT_C);
    assign is_nul   = (rom_q == 8'h00);
    assign advance  = (state == S_STREAM) && load && !at_limit && !is_nul;
    assign rom_en   = (state == S_PRIME) || advance;
    assign rom_addr = ofs_q + fetch_i;
    assign hi_mask  = {hilite_q, 7'b0};
    assign out_addr = base_q + ADDR_W'(out_i);

    // NOTE: ROM read registers have no reset; memories cannot be reset and these
    // registers are always refilled by the PRIME fetch before being consumed.
    always_ff @(posedge clk) begin
        ofs_q <= ofs_rom[idx_q];
        if (rom_en) rom_q <= str_rom[rom_addr];
    end

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // below sees the pre-edge values of the registers it reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            str_len   <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            hilite_q  <= 1'b0;
            fetch_i   <= '0;
            out_i     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        idx_q     <= req_index;
                        base_q    <= req_base;
                        hilite_q  <= req_hilite;
                        fetch_i   <= '0;
                        out_i     <= '0;
                        str_len   <= '0;
                        req_ready <= 1'b0;
                        state     <= S_OFS;
                    end
                end
                S_OFS: state <= S_PRIME;
                S_PRIME: begin
                    fetch_i <= fetch_i + 1'b1;
                    state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (load) begin
                        if (at_limit || (is_nul && !PAD_EN)) begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (is_nul) begin
                            // Pad character goes straight into the output register: no bubble.
                            wr_en   <= 1'b1;
                            wr_addr <= out_addr;
                            wr_data <= PAD_CHAR | hi_mask;
                            out_i   <= out_i + 1'b1;
                            state   <= S_PAD;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= out_addr;
                            wr_data <= rom_q | hi_mask;
                            out_i   <= out_i + 1'b1;
                            fetch_i <= fetch_i + 1'b1;
                            if (str_len != 8'hFF) str_len <= str_len + 8'd1;
                        end
                    end
                end
                S_PAD: begin
                    if (load) begin
                        if (at_limit) begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= out_addr;
                            wr_data <= PAD_CHAR | hi_mask;
                            out_i   <= out_i + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_string_writer.sv
// Directed bench for osd_string_writer: three instances cover FIELD_W = 0, 8 and 3
// against a shared string image ("RGBS", "YPbPr", empty).
`timescale 1ns/1ps
module tb_osd_string_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid, req_ready, wr_en, done;
    logic [5:0]  req_index;
    logic [10:0] req_base;
    logic        req_hilite, wr_ready;
    logic [10:0] wr_addr [3];
    logic [7:0]  wr_data [3];
    logic [7:0]  str_len [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] cap_addr [16];
    logic [7:0]  cap_data [16];
    int          n_wr, first_k, done_k;
    logic [7:0]  cap_len;
    bit          overlap, hold_bad, rdy_at_done;

    always #5 clk = ~clk;

    osd_string_writer #(.FIELD_W(0)) u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_index(req_index), .req_base(req_base), .req_hilite(req_hilite),
        .wr_en(wr_en[0]), .wr_ready(wr_ready), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .done(done[0]), .str_len(str_len[0]));

    osd_string_writer #(.FIELD_W(8)) u8 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_index(req_index), .req_base(req_base), .req_hilite(req_hilite),
        .wr_en(wr_en[1]), .wr_ready(wr_ready), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .done(done[1]), .str_len(str_len[1]));

    osd_string_writer #(.FIELD_W(3)) u3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_index(req_index), .req_base(req_base), .req_hilite(req_hilite),
        .wr_en(wr_en[2]), .wr_ready(wr_ready), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .done(done[2]), .str_len(str_len[2]));

    // String 0 "RGBS" at 0, string 1 "YPbPr" at 5, string 2 empty at 11.
    task automatic load_roms();
        logic [7:0] img [12];
        img = '{8'h52, 8'h47, 8'h42, 8'h53, 8'h00,
                8'h59, 8'h50, 8'h62, 8'h50, 8'h72, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            u0.str_rom[i] = img[i];
            u8.str_rom[i] = img[i];
            u3.str_rom[i] = img[i];
        end
        u0.ofs_rom[0] = 9'd0; u0.ofs_rom[1] = 9'd5; u0.ofs_rom[2] = 9'd11;
        u8.ofs_rom[0] = 9'd0; u8.ofs_rom[1] = 9'd5; u8.ofs_rom[2] = 9'd11;
        u3.ofs_rom[0] = 9'd0; u3.ofs_rom[1] = 9'd5; u3.ofs_rom[2] = 9'd11;
    endtask

    // Presents a request at one rising edge (edge T) and returns just after it.
    task automatic issue(input int d, input logic [5:0] idx, input logic [10:0] base, input logic hi);
        @(negedge clk);
        n_checks++;
        if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready dut%0d: got %b expected 1", d, req_ready[d]);
        end
        req_index = idx; req_base = base; req_hilite = hi; req_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    // Records accepted writes until done; k counts negedges after edge T (k=0 is T..T+1).
    // The write at index stall_idx is refused for stall_n cycles.
    task automatic capture(input int d, input int stall_idx, input int stall_n);
        int          stall_left;
        logic [10:0] ha;
        logic [7:0]  hd;
        stall_left = stall_n; ha = '0; hd = '0;
        n_wr = 0; first_k = -1; done_k = -1; cap_len = '0;
        overlap = 0; hold_bad = 0; rdy_at_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wr_en[d] && done[d]) overlap = 1;
            if (done[d]) begin
                done_k = k; cap_len = str_len[d]; rdy_at_done = req_ready[d];
                break;
            end
            wr_ready = 1'b1;
            if (wr_en[d]) begin
                if (first_k < 0) first_k = k;
                if (n_wr == stall_idx && stall_left < stall_n &&
                    (wr_addr[d] !== ha || wr_data[d] !== hd)) hold_bad = 1;
                if (n_wr == stall_idx && stall_left > 0) begin
                    if (stall_left == stall_n) begin ha = wr_addr[d]; hd = wr_data[d]; end
                    wr_ready = 1'b0;
                    stall_left--;
                end else if (n_wr < 16) begin
                    cap_addr[n_wr] = wr_addr[d];
                    cap_data[n_wr] = wr_data[d];
                    n_wr++;
                end
            end
        end
        wr_ready = 1'b1;
        n_checks++;
        if (done_k < 0) begin
            n_fail++;
            $display("FAIL done_timeout dut%0d: no done within 60 cycles", d);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (wr_en !== 3'b000)     begin n_fail++; $display("FAIL rst_wr_en: got %b expected 000", wr_en); end
        n_checks++; if (wr_addr[0] !== 11'h0) begin n_fail++; $display("FAIL rst_wr_addr: got %h expected 000", wr_addr[0]); end
        n_checks++; if (wr_data[0] !== 8'h0)  begin n_fail++; $display("FAIL rst_wr_data: got %h expected 00", wr_data[0]); end
        n_checks++; if (done !== 3'b000)      begin n_fail++; $display("FAIL rst_done: got %b expected 000", done); end
        n_checks++; if (str_len[0] !== 8'h0)  begin n_fail++; $display("FAIL rst_str_len: got %h expected 00", str_len[0]); end
        n_checks++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 111", req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] ed [4];
        ed = '{8'h52, 8'h47, 8'h42, 8'h53};
        issue(0, 6'd0, 11'h100, 1'b0);
        capture(0, -1, 0);
        n_checks++; if (n_wr != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", n_wr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_addr[i] !== 11'h100 + 11'(i) || cap_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, cap_addr[i], cap_data[i], 11'h100 + 11'(i), ed[i]);
            end
        end
        n_checks++; if (first_k != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", first_k); end
        n_checks++; if (done_k != 7)  begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 7", done_k); end
        n_checks++; if (cap_len !== 8'd4) begin n_fail++; $display("FAIL basic_str_len: got %0d expected 4", cap_len); end
        n_checks++; if (overlap) begin n_fail++; $display("FAIL basic_overlap: got 1 expected 0"); end
        n_checks++; if (rdy_at_done) begin n_fail++; $display("FAIL basic_ready_at_done: got 1 expected 0"); end
        @(negedge clk);
        n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 1", req_ready[0]); end
    endtask

    task automatic test_pad_wrap();
        logic [10:0] ea [8];
        logic [7:0]  ed [8];
        ea = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003, 11'h004, 11'h005};
        ed = '{8'h52, 8'h47, 8'h42, 8'h53, 8'h20, 8'h20, 8'h20, 8'h20};
        issue(1, 6'd0, 11'h7FE, 1'b0);
        capture(1, -1, 0);
        n_checks++; if (n_wr != 8) begin n_fail++; $display("FAIL pad_count: got %0d expected 8", n_wr); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL pad_write%0d: got %h/%h expected %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
            end
        end
        n_checks++; if (done_k != 11) begin n_fail++; $display("FAIL pad_done_cycle: got %0d expected 11", done_k); end
        n_checks++; if (cap_len !== 8'd4) begin n_fail++; $display("FAIL pad_str_len: got %0d expected 4", cap_len); end
    endtask

    task automatic test_truncate();
        logic [7:0] ed [3];
        ed = '{8'h59, 8'h50, 8'h62};
        issue(2, 6'd1, 11'h040, 1'b0);
        capture(2, -1, 0);
        n_checks++; if (n_wr != 3) begin n_fail++; $display("FAIL trunc_count: got %0d expected 3", n_wr); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cap_addr[i] !== 11'h040 + 11'(i) || cap_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL trunc_write%0d: got %h/%h expected %h/%h", i, cap_addr[i], cap_data[i], 11'h040 + 11'(i), ed[i]);
            end
        end
        n_checks++; if (done_k != 6) begin n_fail++; $display("FAIL trunc_done_cycle: got %0d expected 6", done_k); end
        n_checks++; if (cap_len !== 8'd3) begin n_fail++; $display("FAIL trunc_str_len: got %0d expected 3", cap_len); end
    endtask

    task automatic test_hilite();
        logic [7:0] ed [4];
        ed = '{8'hD2, 8'hC7, 8'hC2, 8'hD3};
        issue(0, 6'd0, 11'h200, 1'b1);
        capture(0, -1, 0);
        n_checks++; if (n_wr != 4) begin n_fail++; $display("FAIL hilite_count: got %0d expected 4", n_wr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL hilite_data%0d: got %h expected %h", i, cap_data[i], ed[i]);
            end
        end
        n_checks++; if (cap_len !== 8'd4) begin n_fail++; $display("FAIL hilite_str_len: got %0d expected 4", cap_len); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ed [4];
        ed = '{8'h52, 8'h47, 8'h42, 8'h53};
        issue(0, 6'd0, 11'h100, 1'b0);
        capture(0, 1, 3);
        n_checks++; if (n_wr != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", n_wr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_addr[i] !== 11'h100 + 11'(i) || cap_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, cap_addr[i], cap_data[i], 11'h100 + 11'(i), ed[i]);
            end
        end
        n_checks++; if (hold_bad) begin n_fail++; $display("FAIL bp_hold: outputs changed during stall, expected 101/47 held"); end
        n_checks++; if (done_k != 10) begin n_fail++; $display("FAIL bp_done_cycle: got %0d expected 10", done_k); end
    endtask

    task automatic test_empty();
        issue(0, 6'd2, 11'h300, 1'b0);
        capture(0, -1, 0);
        n_checks++; if (n_wr != 0)  begin n_fail++; $display("FAIL empty0_count: got %0d expected 0", n_wr); end
        n_checks++; if (done_k != 3) begin n_fail++; $display("FAIL empty0_done_cycle: got %0d expected 3", done_k); end
        n_checks++; if (cap_len !== 8'd0) begin n_fail++; $display("FAIL empty0_str_len: got %0d expected 0", cap_len); end
        issue(1, 6'd2, 11'h010, 1'b0);
        capture(1, -1, 0);
        n_checks++; if (n_wr != 8) begin n_fail++; $display("FAIL empty8_count: got %0d expected 8", n_wr); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cap_addr[i] !== 11'h010 + 11'(i) || cap_data[i] !== 8'h20) begin
                n_fail++;
                $display("FAIL empty8_write%0d: got %h/%h expected %h/20", i, cap_addr[i], cap_data[i], 11'h010 + 11'(i));
            end
        end
        n_checks++; if (cap_len !== 8'd0) begin n_fail++; $display("FAIL empty8_str_len: got %0d expected 0", cap_len); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        issue(0, 6'd0, 11'h100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (wr_en[0] !== 1'b1 || wr_addr[0] !== 11'h102) begin
            n_fail++;
            $display("FAIL mid_third_write: got %b/%h expected 1/102", wr_en[0], wr_addr[0]);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (wr_en[0] !== 1'b0)     begin n_fail++; $display("FAIL mid_wr_en: got %b expected 0", wr_en[0]); end
        n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_req_ready: got %b expected 1", req_ready[0]); end
        saw_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done[0]) saw_done = 1;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done[0]) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL mid_no_done: got done pulse expected none"); end
        issue(0, 6'd0, 11'h120, 1'b0);
        capture(0, -1, 0);
        n_checks++; if (n_wr != 4 || first_k != 3) begin n_fail++; $display("FAIL mid_rerun: got %0d writes at %0d expected 4 at 3", n_wr, first_k); end
        n_checks++;
        if (cap_addr[0] !== 11'h120 || cap_data[0] !== 8'h52 || cap_data[3] !== 8'h53) begin
            n_fail++;
            $display("FAIL mid_rerun_data: got %h/%h..%h expected 120/52..53", cap_addr[0], cap_data[0], cap_data[3]);
        end
        n_checks++; if (cap_len !== 8'd4) begin n_fail++; $display("FAIL mid_rerun_str_len: got %0d expected 4", cap_len); end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_index  = '0;
        req_base   = '0;
        req_hilite = 1'b0;
        wr_ready   = 1'b1;
        load_roms();
        test_reset();
        test_basic();
        test_pad_wrap();
        test_truncate();
        test_hilite();
        test_backpressure();
        test_empty();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
